// File: rtl/led_shifter_main.sv
// Ping-pong LED shifter: a single lit LED steps once every TOPVALUE clocks and
// bounces between bit 0 and bit SHIFT_BITS-1 without dwelling twice at either end.
module led_shifter_main #(
  parameter int SHIFT_BITS = 4,
  parameter int TOPVALUE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [SHIFT_BITS-1:0] qLeds
);

  localparam int CW = (TOPVALUE > 1) ? $clog2(TOPVALUE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TOPVALUE - 1);

  if (SHIFT_BITS < 1 || TOPVALUE < 1) begin : g_bad_params
    $error("led_shifter_main: SHIFT_BITS and TOPVALUE must both be >= 1");
  end

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  step;
  dir_t                  state;
  dir_t                  state_next;
  logic [SHIFT_BITS-1:0] leds_next;

  // Prescaler: step is high for the single cycle in which cnt sits at its maximum.
  assign step     = (cnt == CNT_MAX);
  assign cnt_next = step ? '0 : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= LEFT;
      qLeds <= SHIFT_BITS'(1);
    end else begin
      cnt   <= cnt_next;
      state <= state_next;
      qLeds <= leds_next;
    end
  end

  // The direction flips on the same step that lights an end LED, so each end
  // LED is lit for exactly one step per bounce.
  always_comb begin
    leds_next  = qLeds;
    state_next = state;
    if (step && SHIFT_BITS > 1) begin
      case (state)
        LEFT: begin
          leds_next = qLeds << 1;
          if (leds_next[SHIFT_BITS-1]) state_next = RIGHT;
        end
        RIGHT: begin
          leds_next = qLeds >> 1;
          if (leds_next[0]) state_next = LEFT;
        end
        default: begin
          leds_next  = SHIFT_BITS'(1);
          state_next = LEFT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_shifter_main.sv
// Directed bench for led_shifter_main: default 4x8 instance, a 2-LED/TOPVALUE=1
// instance and a single-LED instance, all sharing one clock and reset.
module tb_led_shifter_main;

  logic       clk;
  logic       rst;
  logic [3:0] q_def;
  logic [1:0] q_fast;
  logic [0:0] q_one;

  int n_checks;
  int n_fail;
  bit armed;

  led_shifter_main #(.SHIFT_BITS(4), .TOPVALUE(8)) dut_def (
    .clk(clk), .rst(rst), .qLeds(q_def)
  );

  led_shifter_main #(.SHIFT_BITS(2), .TOPVALUE(1)) dut_fast (
    .clk(clk), .rst(rst), .qLeds(q_fast)
  );

  led_shifter_main #(.SHIFT_BITS(1), .TOPVALUE(8)) dut_one (
    .clk(clk), .rst(rst), .qLeds(q_one)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // One-hot invariant on every instance, every cycle after the first reset edge.
  always @(negedge clk) begin
    if (armed) begin
      n_checks = n_checks + 1;
      if ($isunknown(q_def) || !$onehot(q_def)) begin
        n_fail = n_fail + 1;
        $display("FAIL onehot_def: got %b, required one-hot", q_def);
      end
      n_checks = n_checks + 1;
      if ($isunknown(q_fast) || !$onehot(q_fast)) begin
        n_fail = n_fail + 1;
        $display("FAIL onehot_fast: got %b, required one-hot", q_fast);
      end
      n_checks = n_checks + 1;
      if (q_one !== 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL onehot_one: got %b, required 1", q_one);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected default-instance pattern n rising edges after reset release.
  function automatic logic [3:0] exp_def(input int n);
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0100; seq[5] = 4'b0010;
    return seq[(n / 8) % 6];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      armed = 1'b1;
      n_checks = n_checks + 1;
      if (q_def !== 4'b0001) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_q_def cyc %0d: got %b, required 0001", i, q_def);
      end
      n_checks = n_checks + 1;
      if (dut_def.cnt !== 3'd0) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_cnt cyc %0d: got %0d, required 0", i, dut_def.cnt);
      end
      n_checks = n_checks + 1;
      if (q_fast !== 2'b01) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_q_fast cyc %0d: got %b, required 01", i, q_fast);
      end
    end
  endtask

  // Runs edges first..last after a reset release, checking pattern and prescaler.
  task automatic run_def(input int first, input int last, input string tag);
    for (int n = first; n <= last; n++) begin
      tick();
      n_checks = n_checks + 1;
      if (q_def !== exp_def(n)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_q edge %0d: got %b, required %b", tag, n, q_def, exp_def(n));
      end
      n_checks = n_checks + 1;
      if (dut_def.cnt !== 3'(n % 8)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_cnt edge %0d: got %0d, required %0d", tag, n, dut_def.cnt, n % 8);
      end
    end
  endtask

  task automatic test_prescale();
    rst = 1'b0;
    run_def(1, 8, "prescale");
  endtask

  task automatic test_bounce();
    run_def(9, 100, "bounce");
  endtask

  task automatic test_mid_reset();
    // Edge 131 (131 % 48 == 35) is inside the 0100 step on the way back down.
    run_def(101, 131, "pre_reset");
    n_checks = n_checks + 1;
    if (q_def !== 4'b0100) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_setup: got %b, required 0100", q_def);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks = n_checks + 1;
    if (q_def !== 4'b0001) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_q: got %b, required 0001", q_def);
    end
    n_checks = n_checks + 1;
    if (dut_def.cnt !== 3'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_reset_cnt: got %0d, required 0", dut_def.cnt);
    end
    run_def(1, 20, "post_reset");
  endtask

  task automatic test_fast();
    rst = 1'b1;
    tick();
    tick();
    n_checks = n_checks + 1;
    if (q_fast !== 2'b01) begin
      n_fail = n_fail + 1;
      $display("FAIL fast_reset: got %b, required 01", q_fast);
    end
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      n_checks = n_checks + 1;
      if (q_fast !== ((n % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail = n_fail + 1;
        $display("FAIL fast_toggle edge %0d: got %b, required %b", n, q_fast,
                 (n % 2 == 1) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_single();
    for (int n = 1; n <= 50; n++) begin
      tick();
      n_checks = n_checks + 1;
      if (q_one !== 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL single_const edge %0d: got %b, required 1", n, q_one);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_prescale();
    test_bounce();
    test_mid_reset();
    test_fast();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
